// File: rtl/button_display_ctrl_pkg.sv
// Shared definitions for the button overlay controller: button indices,
// FSM state type and a one-hot helper used by demo mode.
package button_display_ctrl_pkg;

  localparam int unsigned NUM_BTNS = 12;

  // Bit positions in raw_buttons / btn_show; the renderer uses the same order.
  typedef enum logic [3:0] {
    BTN_A      = 4'd0,
    BTN_B      = 4'd1,
    BTN_X      = 4'd2,
    BTN_Y      = 4'd3,
    BTN_START  = 4'd4,
    BTN_L      = 4'd5,
    BTN_R      = 4'd6,
    BTN_Z      = 4'd7,
    BTN_DUP    = 4'd8,
    BTN_DDOWN  = 4'd9,
    BTN_DRIGHT = 4'd10,
    BTN_DLEFT  = 4'd11
  } btn_e;

  typedef enum logic [1:0] {
    ST_LIVE     = 2'd0,
    ST_DEMO_ON  = 2'd1,
    ST_DEMO_OFF = 2'd2
  } state_e;

  // Single lit button for demo mode.
  function automatic logic [NUM_BTNS-1:0] onehot(input logic [3:0] idx);
    return {{(NUM_BTNS-1){1'b0}}, 1'b1} << idx;
  endfunction

endpackage

// File: rtl/button_filter.sv
// One button's debounce and release-stretch filter, advanced once per frame tick.
module button_filter #(
  parameter int unsigned DEB_FRAMES  = 2,
  parameter int unsigned HOLD_FRAMES = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic tick,
  input  logic pend,
  output logic deb,
  output logic live,
  output logic rise
);

  localparam int unsigned CW = $clog2(DEB_FRAMES + 1);
  // A zero-width hold counter is not legal, so HOLD_FRAMES=0 keeps one constant-zero bit.
  localparam int unsigned HW = (HOLD_FRAMES > 0) ? $clog2(HOLD_FRAMES + 1) : 1;
  localparam logic [CW-1:0] CNT_LAST  = CW'(DEB_FRAMES - 1);
  localparam logic [HW-1:0] HOLD_INIT = HW'(HOLD_FRAMES);

  logic          deb_q, deb_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [HW-1:0] hold_q, hold_d;

  // Next filter state as it would be after a tick; only committed on a tick.
  always_comb begin
    deb_d  = deb_q;
    cnt_d  = '0;
    hold_d = hold_q;
    if (pend != deb_q) begin
      if (cnt_q == CNT_LAST) begin
        deb_d = pend;
      end else if (cnt_q < CNT_LAST) begin
        cnt_d = cnt_q + 1'b1;
      end else begin
        cnt_d = cnt_q;
      end
    end
    if (deb_d) begin
      hold_d = HOLD_INIT;
    end else if (hold_q != '0) begin
      hold_d = hold_q - 1'b1;
    end
  end

  // Filter registers advance only on frame ticks.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      deb_q  <= 1'b0;
      cnt_q  <= '0;
      hold_q <= '0;
    end else if (tick) begin
      deb_q  <= deb_d;
      cnt_q  <= cnt_d;
      hold_q <= hold_d;
    end
  end

  assign deb  = deb_q;
  assign live = deb_d | (hold_d != '0);
  assign rise = tick & deb_d & ~deb_q;

endmodule

// File: rtl/button_display_ctrl.sv
// Frame-synchronous button enable sequencer for the input viewer overlay:
// pending latch, vsync edge detect, per-button filters and live/demo FSM.
module button_display_ctrl
  import button_display_ctrl_pkg::*;
#(
  parameter int unsigned DEB_FRAMES  = 2,
  parameter int unsigned HOLD_FRAMES = 4,
  parameter int unsigned DEMO_FRAMES = 30
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                vsync,
  input  logic                raw_valid,
  input  logic [NUM_BTNS-1:0] raw_buttons,
  input  logic                demo_en,
  output logic [NUM_BTNS-1:0] btn_show,
  output logic                demo_active,
  output logic [3:0]          demo_idx
);

  localparam int unsigned DCW = $clog2(DEMO_FRAMES + 1);
  localparam logic [DCW-1:0] DCNT_LAST = DCW'(DEMO_FRAMES - 1);

  logic                vsync_q, vsync_d;
  logic                armed_q, armed_d;
  logic [NUM_BTNS-1:0] pend_q, pend_d;
  state_e              state_q, state_d;
  logic [NUM_BTNS-1:0] btn_show_q, btn_show_d;
  logic                demo_active_q, demo_active_d;
  logic [3:0]          demo_idx_q, demo_idx_d;
  logic [DCW-1:0]      dcnt_q, dcnt_d;

  logic                frame_tick;
  logic [NUM_BTNS-1:0] live;
  logic [NUM_BTNS-1:0] rise;
  logic [NUM_BTNS-1:0] unused_deb;
  logic [3:0]          idx_next;

  // armed_q blocks a tick on the first cycle after reset even if vsync is already high.
  always_comb begin
    vsync_d    = vsync;
    armed_d    = 1'b1;
    frame_tick = vsync & ~vsync_q & armed_q;
    pend_d     = raw_valid ? raw_buttons : pend_q;
  end

  for (genvar i = 0; i < NUM_BTNS; i++) begin : g_btn
    button_filter #(
      .DEB_FRAMES (DEB_FRAMES),
      .HOLD_FRAMES(HOLD_FRAMES)
    ) u_filter (
      .clk  (clk),
      .rst_n(rst_n),
      .tick (frame_tick),
      .pend (pend_q[i]),
      .deb  (unused_deb[i]),
      .live (live[i]),
      .rise (rise[i])
    );
  end

  // Live/demo sequencing, evaluated on frame ticks; exit outranks all other moves.
  always_comb begin
    state_d    = state_q;
    btn_show_d = btn_show_q;
    demo_idx_d = demo_idx_q;
    dcnt_d     = dcnt_q;
    idx_next   = (demo_idx_q == 4'(BTN_DLEFT)) ? 4'd0 : demo_idx_q + 4'd1;
    if (frame_tick) begin
      case (state_q)
        ST_LIVE: begin
          if (demo_en) begin
            state_d    = ST_DEMO_ON;
            demo_idx_d = 4'd0;
            dcnt_d     = '0;
            btn_show_d = onehot(4'd0);
          end else begin
            btn_show_d = live;
          end
        end
        ST_DEMO_ON, ST_DEMO_OFF: begin
          if (!demo_en || (|rise)) begin
            state_d    = ST_LIVE;
            btn_show_d = live;
            demo_idx_d = 4'd0;
            dcnt_d     = '0;
          end else if (state_q == ST_DEMO_OFF) begin
            state_d    = ST_DEMO_ON;
            demo_idx_d = idx_next;
            dcnt_d     = '0;
            btn_show_d = onehot(idx_next);
          end else if (dcnt_q == DCNT_LAST) begin
            state_d    = ST_DEMO_OFF;
            btn_show_d = '0;
          end else begin
            dcnt_d     = dcnt_q + 1'b1;
            btn_show_d = onehot(demo_idx_q);
          end
        end
        default: begin
          state_d    = ST_LIVE;
          btn_show_d = live;
          demo_idx_d = 4'd0;
          dcnt_d     = '0;
        end
      endcase
    end
    demo_active_d = (state_d != ST_LIVE);
  end

  // All top-level state, cleared synchronously.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      vsync_q       <= 1'b0;
      armed_q       <= 1'b0;
      pend_q        <= '0;
      state_q       <= ST_LIVE;
      btn_show_q    <= '0;
      demo_active_q <= 1'b0;
      demo_idx_q    <= 4'd0;
      dcnt_q        <= '0;
    end else begin
      vsync_q       <= vsync_d;
      armed_q       <= armed_d;
      pend_q        <= pend_d;
      state_q       <= state_d;
      btn_show_q    <= btn_show_d;
      demo_active_q <= demo_active_d;
      demo_idx_q    <= demo_idx_d;
      dcnt_q        <= dcnt_d;
    end
  end

  assign btn_show    = btn_show_q;
  assign demo_active = demo_active_q;
  assign demo_idx    = demo_idx_q;

endmodule

// File: tb/tb_button_display_ctrl.sv
// Self-checking bench for button_display_ctrl against a frame-level reference model.
module tb_button_display_ctrl;

  localparam int DEB  = 2;
  localparam int HOLD = 4;
  localparam int DEMO = 2;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        vsync;
  logic        raw_valid;
  logic [11:0] raw_buttons;
  logic        demo_en;
  logic [11:0] btn_show;
  logic        demo_active;
  logic [3:0]  demo_idx;

  always #5 clk = ~clk;

  button_display_ctrl #(
    .DEB_FRAMES (DEB),
    .HOLD_FRAMES(HOLD),
    .DEMO_FRAMES(DEMO)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .vsync      (vsync),
    .raw_valid  (raw_valid),
    .raw_buttons(raw_buttons),
    .demo_en    (demo_en),
    .btn_show   (btn_show),
    .demo_active(demo_active),
    .demo_idx   (demo_idx)
  );

  int vecs = 0;
  int errs = 0;

  // Reference model: per-button run lengths and last-pressed frame numbers,
  // demo position as a frame count since demo entry.
  logic [11:0] m_pend, m_deb, m_show;
  int          m_run[12];
  int          m_last1[12];
  int          m_ticks;
  bit          m_demo;
  int          m_p;
  int          m_idx;
  bit          m_vs_prev, m_armed;

  task automatic model_reset();
    m_pend = '0; m_deb = '0; m_show = '0;
    for (int b = 0; b < 12; b++) begin
      m_run[b]   = 0;
      m_last1[b] = -100000;
    end
    m_ticks = 0; m_demo = 0; m_p = 0; m_idx = 0;
    m_vs_prev = 0; m_armed = 0;
  endtask

  task automatic model_tick();
    logic [11:0] lv;
    bit rose;
    rose = 0;
    m_ticks++;
    for (int b = 0; b < 12; b++) begin
      if (m_pend[b] == m_deb[b]) m_run[b] = 0;
      else begin
        m_run[b]++;
        if (m_run[b] >= DEB) begin
          m_deb[b] = m_pend[b];
          m_run[b] = 0;
          if (m_deb[b]) rose = 1;
        end
      end
      if (m_deb[b]) m_last1[b] = m_ticks;
      lv[b] = m_deb[b] || ((m_ticks - m_last1[b]) < HOLD);
    end
    if (m_demo) begin
      if (!demo_en || rose) begin
        m_demo = 0; m_show = lv; m_idx = 0;
      end else begin
        m_p++;
        m_idx  = (m_p / (DEMO + 1)) % 12;
        m_show = ((m_p % (DEMO + 1)) < DEMO) ? 12'(1 << m_idx) : 12'h000;
      end
    end else if (demo_en) begin
      m_demo = 1; m_p = 0; m_idx = 0; m_show = 12'h001;
    end else begin
      m_show = lv;
    end
  endtask

  // One clock with the given inputs; the model follows the same edge.
  task automatic cyc(input bit vs, input bit rv, input logic [11:0] raw);
    vsync = vs; raw_valid = rv; raw_buttons = raw;
    @(posedge clk);
    if (!rst_n) model_reset();
    else begin
      if (vs && !m_vs_prev && m_armed) model_tick();
      if (rv) m_pend = raw;
      m_vs_prev = vs;
      m_armed   = 1;
    end
    #1;
  endtask

  task automatic frame(input bit rv, input logic [11:0] raw);
    cyc(0, rv, raw);
    cyc(1, 0, raw);
    cyc(0, 0, raw);
  endtask

  task automatic test_reset();
    rst_n = 0; demo_en = 0;
    cyc(1, 0, 12'h000);
    cyc(0, 1, 12'hFFF);
    cyc(1, 0, 12'h000);
    vecs++;
    if ({btn_show, demo_active, demo_idx} !== 17'h0) begin
      errs++;
      $display("FAIL reset_state: got show=%h act=%b idx=%0d, want all zero", btn_show, demo_active, demo_idx);
    end
    rst_n = 1;
    cyc(1, 1, 12'hFFF);
    cyc(1, 0, 12'h000);
    cyc(0, 1, 12'h000);
    vecs++;
    if (btn_show !== 12'h000 || btn_show !== m_show || demo_active !== 1'b0) begin
      errs++;
      $display("FAIL reset_first_cycle: got show=%h act=%b, want show=000 act=0", btn_show, demo_active);
    end
    frame(0, 12'h000);
    vecs++;
    if (btn_show !== m_show || demo_active !== m_demo || demo_idx !== 4'(m_idx)) begin
      errs++;
      $display("FAIL reset_first_tick: got show=%h act=%b idx=%0d, want show=%h act=%b idx=%0d",
               btn_show, demo_active, demo_idx, m_show, m_demo, m_idx);
    end
  endtask

  task automatic test_debounce();
    frame(1, 12'h001);
    vecs++;
    if (btn_show !== 12'h000 || btn_show !== m_show) begin
      errs++;
      $display("FAIL debounce_tick1: got show=%h, want %h", btn_show, m_show);
    end
    frame(0, 12'h001);
    vecs++;
    if (btn_show !== 12'h001 || btn_show !== m_show) begin
      errs++;
      $display("FAIL debounce_tick2: got show=%h, want 001", btn_show);
    end
    frame(1, 12'h003);
    frame(1, 12'h001);
    for (int f = 0; f < 3; f++) begin
      vecs++;
      if (btn_show[1] !== 1'b0 || btn_show !== m_show) begin
        errs++;
        $display("FAIL debounce_glitch: frame %0d got show=%h, want %h", f, btn_show, m_show);
      end
      frame(0, 12'h001);
    end
  endtask

  task automatic test_hold();
    cyc(0, 1, 12'h000);
    for (int f = 0; f < 8; f++) begin
      for (int c = 0; c < 4; c++) begin
        cyc(c == 1, 0, 12'h000);
        vecs++;
        if (btn_show !== m_show || demo_active !== m_demo) begin
          errs++;
          $display("FAIL hold: frame %0d cycle %0d got show=%h, want %h", f, c, btn_show, m_show);
        end
      end
    end
  endtask

  task automatic test_demo();
    demo_en = 1;
    for (int f = 0; f < 40; f++) begin
      frame(0, 12'h000);
      vecs++;
      if (btn_show !== m_show || demo_active !== m_demo || demo_idx !== 4'(m_idx)) begin
        errs++;
        $display("FAIL demo_seq: frame %0d got show=%h act=%b idx=%0d, want show=%h act=%b idx=%0d",
                 f, btn_show, demo_active, demo_idx, m_show, m_demo, m_idx);
      end
    end
  endtask

  task automatic test_exit();
    int guard;
    guard = 0;
    while (!(m_demo && m_idx == 5 && (m_p % (DEMO + 1)) == 0) && guard < 60) begin
      frame(0, 12'h000);
      guard++;
    end
    vecs++;
    if (guard >= 60 || demo_idx !== 4'd5 || demo_active !== 1'b1) begin
      errs++;
      $display("FAIL exit_reach_idx5: got act=%b idx=%0d after %0d frames, want act=1 idx=5", demo_active, demo_idx, guard);
    end
    frame(1, 12'h002);
    vecs++;
    if (btn_show !== m_show || demo_active !== m_demo || demo_idx !== 4'(m_idx)) begin
      errs++;
      $display("FAIL exit_press_tick1: got show=%h act=%b idx=%0d, want show=%h act=%b idx=%0d",
               btn_show, demo_active, demo_idx, m_show, m_demo, m_idx);
    end
    frame(0, 12'h002);
    vecs++;
    if (btn_show !== 12'h002 || demo_active !== 1'b0 || demo_idx !== 4'd0 || btn_show !== m_show) begin
      errs++;
      $display("FAIL exit_on_rise: got show=%h act=%b idx=%0d, want show=002 act=0 idx=0", btn_show, demo_active, demo_idx);
    end
    frame(0, 12'h002);
    vecs++;
    if (demo_active !== 1'b1 || btn_show !== m_show || demo_active !== m_demo) begin
      errs++;
      $display("FAIL exit_reenter: got show=%h act=%b, want show=%h act=1", btn_show, demo_active, m_show);
    end
    frame(0, 12'h002);
    demo_en = 0;
    frame(0, 12'h002);
    vecs++;
    if (demo_active !== 1'b0 || demo_idx !== 4'd0 || btn_show !== m_show) begin
      errs++;
      $display("FAIL exit_demo_en_drop: got show=%h act=%b idx=%0d, want show=%h act=0 idx=0",
               btn_show, demo_active, demo_idx, m_show);
    end
    frame(1, 12'h000);
    for (int f = 0; f < 7; f++) frame(0, 12'h000);
    vecs++;
    if (btn_show !== 12'h000 || btn_show !== m_show) begin
      errs++;
      $display("FAIL exit_release: got show=%h, want 000", btn_show);
    end
  endtask

  task automatic test_back_to_back();
    cyc(0, 0, 12'h000);
    cyc(1, 1, 12'h010);
    cyc(0, 0, 12'h000);
    vecs++;
    if (btn_show !== 12'h000 || btn_show !== m_show) begin
      errs++;
      $display("FAIL collision_old_pending: got show=%h, want 000", btn_show);
    end
    frame(0, 12'h000);
    vecs++;
    if (btn_show !== 12'h000 || btn_show !== m_show) begin
      errs++;
      $display("FAIL collision_tick1: got show=%h, want 000", btn_show);
    end
    frame(0, 12'h000);
    vecs++;
    if (btn_show !== 12'h010 || btn_show !== m_show) begin
      errs++;
      $display("FAIL collision_tick2: got show=%h, want 010", btn_show);
    end
    demo_en = 1;
    for (int f = 0; f < 4; f++) frame(0, 12'h000);
    rst_n = 0;
    cyc(0, 0, 12'h000);
    vecs++;
    if ({btn_show, demo_active, demo_idx} !== 17'h0) begin
      errs++;
      $display("FAIL reset_mid_demo: got show=%h act=%b idx=%0d, want all zero", btn_show, demo_active, demo_idx);
    end
    rst_n = 1; demo_en = 0;
    frame(0, 12'h000);
    vecs++;
    if (btn_show !== m_show || demo_active !== 1'b0 || btn_show !== 12'h000) begin
      errs++;
      $display("FAIL after_reset_mid_demo: got show=%h act=%b, want show=000 act=0", btn_show, demo_active);
    end
  endtask

  task automatic test_random();
    logic [11:0] r;
    int gap;
    for (int f = 0; f < 300; f++) begin
      if ($urandom_range(0, 15) == 0) demo_en = ~demo_en;
      gap = $urandom_range(1, 3);
      for (int c = 0; c <= gap; c++) begin
        r = 12'($urandom_range(0, 4095));
        cyc(c == gap, $urandom_range(0, 3) == 0, r);
        vecs++;
        if (btn_show !== m_show || demo_active !== m_demo || demo_idx !== 4'(m_idx)) begin
          errs++;
          $display("FAIL random: frame %0d cycle %0d got show=%h act=%b idx=%0d, want show=%h act=%b idx=%0d",
                   f, c, btn_show, demo_active, demo_idx, m_show, m_demo, m_idx);
        end
      end
      cyc(0, 0, 12'h000);
    end
  endtask

  initial begin
    rst_n = 0; vsync = 0; raw_valid = 0; raw_buttons = '0; demo_en = 0;
    model_reset();
    test_reset();
    test_debounce();
    test_hold();
    test_demo();
    test_exit();
    test_back_to_back();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
